bcd_to_bin: RTL and testbench



---
 rtl/bcd_to_bin.sv | 138 +++++++++++++
 tb/tb_bcd_to_bin.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential BCD-to-binary converter (reverse double-dabble).
// A packed DIGITS-digit BCD value is shifted right one bit per cycle into a
// binary accumulator, with every BCD digit corrected by -3 when it reaches 8
// or more. The latency is a fixed 4*DIGITS+1 cycles from accept to valid.
// Any digit above 9 still runs the full iteration count, then reports err=1
// with a zero result.
module bcd_to_bin #(
  parameter int DIGITS = 8,
  parameter int W      = 27
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  ready,
  output logic                  valid,
  output logic [W-1:0]          bin_out,
  output logic                  err
);

  localparam int NB = 4 * DIGITS;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [NB-1:0]  bcd_q, bcd_d;
  logic [NB-1:0]  acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           bad_q, bad_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   bin_q, bin_d;
  logic           err_q, err_d;

  logic [NB-1:0]     bcd_shift;
  logic [NB-1:0]     bcd_corr;
  logic [NB-1:0]     acc_shift;
  logic [W-1:0]      acc_w;
  logic [DIGITS-1:0] digit_bad;

  // The {bcd, acc} pair shifts right as one register: bcd LSB feeds acc MSB.
  assign bcd_shift = {1'b0, bcd_q[NB-1:1]};
  assign acc_shift = {bcd_q[0], acc_q[NB-1:1]};

  // Per-digit logic: illegal-digit detection on the input and the -3
  // correction after the shift. A digit >= 8 cannot underflow when 3 is
  // subtracted, so plain 4-bit arithmetic is enough.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
      assign bcd_corr[4*gi +: 4] = (bcd_shift[4*gi +: 4] >= 4'd8)
                                   ? (bcd_shift[4*gi +: 4] - 4'd3)
                                   : bcd_shift[4*gi +: 4];
    end

    // Fit the accumulator to the output width; upper acc bits beyond W are
    // always zero for legal input.
    if (W <= NB) begin : g_trunc
      assign acc_w = acc_q[W-1:0];
    end else begin : g_ext
      assign acc_w = {{(W - NB){1'b0}}, acc_q};
    end
  endgenerate

  // Next-state and datapath control for IDLE -> CONV -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    valid_d = 1'b0;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = bcd_in;
          acc_d   = '0;
          cnt_d   = '0;
          bad_d   = |digit_bad;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = bcd_corr;
        acc_d = acc_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bin_d   = bad_q ? '0 : acc_w;
        err_d   = bad_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in progress.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      valid_q <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      valid_q <= valid_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign valid   = valid_q;
  assign bin_out = bin_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: directed and swept checks of bcd_to_bin (default 8 digits).
// A cycle-level model predicts ready/valid/bin_out/err from the decimal value
// of each accepted input and the fixed latency; literal expectations pin it.
module tb_bcd_to_bin;

  localparam int LAT = 33;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] bcd_in;
  logic        ready;
  logic        valid;
  logic [26:0] bin_out;
  logic        err;

  int n_vec  = 0;
  int n_miss = 0;

  bcd_to_bin dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .ready   (ready),
    .valid   (valid),
    .bin_out (bin_out),
    .err     (err)
  );

  always #10 sys_clk = ~sys_clk;

  // Decimal meaning of a packed BCD word; any digit above 9 makes it invalid.
  function automatic void bcd_value(input logic [31:0] v,
                                    output logic [26:0] b, output logic e);
    longint acc;
    acc = 0;
    e   = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      int d;
      d = int'(v[4*i +: 4]);
      if (d > 9) e = 1'b1;
      acc = acc * 10 + longint'(d);
    end
    b = e ? 27'd0 : acc[26:0];
  endfunction

  // Model state: edges remaining until the valid edge, and expected outputs.
  int          m_rem   = 0;
  logic        m_valid = 1'b0;
  logic [26:0] m_bin   = '0;
  logic        m_err   = 1'b0;
  logic [26:0] p_bin   = '0;
  logic        p_err   = 1'b0;
  bit          chk_en  = 1'b0;

  always @(posedge sys_clk) begin
    if (rst) begin
      m_rem   = 0;
      m_valid = 1'b0;
      m_bin   = '0;
      m_err   = 1'b0;
      chk_en  = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_valid = 1'b1;
          m_bin   = p_bin;
          m_err   = p_err;
        end
      end else if (start) begin
        m_rem = LAT;
        bcd_value(bcd_in, p_bin, p_err);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge sys_clk) begin
    if (chk_en) begin
      n_vec++;
      if (ready !== (m_rem == 0) || valid !== m_valid ||
          bin_out !== m_bin || err !== m_err) begin
        n_miss++;
        $display("FAIL cycle t=%0t got ready=%b valid=%b bin=%0d err=%b want ready=%b valid=%b bin=%0d err=%b",
                 $time, ready, valid, bin_out, err, (m_rem == 0), m_valid, m_bin, m_err);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Present a request on the next negedge; it is taken at the following edge.
  task automatic start_req(input logic [31:0] v);
    @(negedge sys_clk);
    bcd_in = v;
    start  = 1'b1;
    @(posedge sys_clk);
    #1;
    start  = 1'b0;
    bcd_in = $urandom;
  endtask

  // Count edges after the accept edge until valid; optionally pulse start at
  // two points during the conversion (those must be ignored).
  task automatic wait_valid(input int p1, input int p2, output int n);
    n = 0;
    while (n < 100) begin
      @(posedge sys_clk);
      #1;
      n++;
      if (valid) break;
      if (n == p1 || n == p2) begin
        start  = 1'b1;
        bcd_in = 32'h0000_0001;
      end else begin
        start  = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_conv(input logic [31:0] v, input logic [26:0] lit_bin,
                          input logic lit_err);
    int n;
    start_req(v);
    wait_valid(-1, -1, n);
    check("latency", n, LAT);
    check("bin_out", 32'(bin_out), 32'(lit_bin));
    check("err", 32'(err), 32'(lit_err));
    $display("conv bcd=0x%08h bin=%0d err=%b latency=%0d", v, bin_out, err, n);
  endtask

  initial begin
    int n;
    int nv;
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_bin", 32'(bin_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    run_conv(32'h0000_0000, 27'd0, 1'b0);
    run_conv(32'h9999_9999, 27'h5F5E0FF, 1'b0);
    run_conv(32'h1234_5678, 27'hBC614E, 1'b0);
    run_conv(32'h0000_000A, 27'd0, 1'b1);
    run_conv(32'h0000_0042, 27'd42, 1'b0);

    // Starts during a conversion are dropped, not queued.
    start_req(32'h0005_0000);
    wait_valid(4, 19, n);
    check("ignore_latency", n, LAT);
    check("ignore_bin", 32'(bin_out), 32'd50000);
    $display("conv bcd=0x00050000 bin=%0d err=%b latency=%0d (starts ignored)", bin_out, err, n);
    // Back-to-back: this request is presented during the valid cycle.
    run_conv(32'h0000_0001, 27'd1, 1'b0);

    // Reset mid-conversion aborts it.
    start_req(32'h8765_4321);
    repeat (9) @(posedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_bin", 32'(bin_out), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    nv = 0;
    repeat (40) begin
      @(posedge sys_clk);
      #1;
      if (valid) nv++;
    end
    check("abort_no_valid", nv, 0);
    $display("abort after reset: valids in 40 cycles=%0d", nv);
    run_conv(32'h8765_4321, 27'd87654321, 1'b0);

    // Sweep of legal values; expected value accumulated while building digits.
    for (int t = 0; t < 1000; t++) begin
      logic [31:0] v;
      int          dec;
      dec = 0;
      v   = '0;
      for (int i = 7; i >= 0; i--) begin
        int d;
        d   = int'($urandom_range(0, 9));
        v   = {v[27:0], 4'(d)};
        dec = dec * 10 + d;
      end
      run_conv(v, 27'(dec), 1'b0);
    end

    @(negedge sys_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
